// File: rtl/imem_load_arb_if.sv
// Bundle of the loader, CPU fetch and memory-port signals of imem_load_arb.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface imem_load_arb_if #(
  parameter int AW = 8,
  parameter int DW = 24
);
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          cpu_hold;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          load_busy;
  logic          load_err;
  logic [AW:0]   words_loaded;

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, cpu_req, cpu_addr, mem_rdata,
    output ld_ready, cpu_rdata, cpu_rvalid, cpu_hold, mem_addr, mem_we, mem_wdata,
           load_busy, load_err, words_loaded
  );

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, cpu_req, cpu_addr, mem_rdata,
    input  ld_ready, cpu_rdata, cpu_rvalid, cpu_hold, mem_addr, mem_we, mem_wdata,
           load_busy, load_err, words_loaded
  );
endinterface

// File: rtl/imem_load_arb.sv
// Shares one instruction-memory port between CPU fetches and a byte-wide loader
// that packs MSB-first words and writes them at sequential addresses from 0.
module imem_load_arb #(
  parameter int AW  = 8,
  parameter int DW  = 24,
  parameter int BPW = 3
) (
  input  logic             clk,
  input  logic             rst,
  imem_load_arb_if.slave   bus
);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WCW = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {S_RUN, S_LOAD, S_WRITE} state_t;

  state_t         r_state;
  logic [AW-1:0]  r_wptr;
  logic [AW:0]    r_words;
  logic [BCW-1:0] r_bcnt;
  logic [DW-1:0]  r_asm;
  logic           r_last;
  logic           r_err;
  logic [DW-1:0]  r_rdata;
  logic           r_rvalid;

  logic [DW-1:0]  w_asm_fill;
  logic           w_word_done;

  // Byte lane k takes the incoming byte only when it is the one being filled.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    assign w_asm_fill[DW-1-8*gi -: 8] = (r_bcnt == BCW'(gi)) ? bus.ld_data
                                                              : r_asm[DW-1-8*gi -: 8];
  end

  assign w_word_done = bus.ld_last || (r_bcnt == BCW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_wptr   <= '0;
      r_words  <= '0;
      r_bcnt   <= '0;
      r_asm    <= '0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_RUN: begin
          // A read issued alongside ld_start is still served.
          if (bus.cpu_req) begin
            r_rdata  <= bus.mem_rdata;
            r_rvalid <= 1'b1;
          end
          if (bus.ld_start) begin
            r_state <= S_LOAD;
            r_wptr  <= '0;
            r_words <= '0;
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.ld_valid) begin
            r_asm <= w_asm_fill;
            if (w_word_done) begin
              r_state <= S_WRITE;
              r_last  <= bus.ld_last;
              if (bus.ld_last && (r_bcnt != BCW'(BPW - 1)))
                r_err <= 1'b1;
            end else begin
              r_bcnt <= r_bcnt + BCW'(1);
            end
          end
        end
        S_WRITE: begin
          r_wptr  <= r_wptr + AW'(1);
          r_words <= r_words + WCW'(1);
          r_bcnt  <= '0;
          r_asm   <= '0;
          r_last  <= 1'b0;
          // A full memory ends the load rather than wrapping onto address 0.
          if (r_last) begin
            r_state <= S_RUN;
          end else if (r_wptr == LAST_ADDR) begin
            r_state <= S_RUN;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Gating with rst keeps a WRITE caught by reset from reaching the memory.
  assign bus.mem_we       = (r_state == S_WRITE) && !rst;
  assign bus.ld_ready     = (r_state == S_LOAD) && !rst;
  assign bus.mem_addr     = (r_state == S_RUN) ? bus.cpu_addr : r_wptr;
  assign bus.mem_wdata    = r_asm;
  assign bus.cpu_hold     = (r_state != S_RUN);
  assign bus.load_busy    = (r_state != S_RUN);
  assign bus.cpu_rdata    = r_rdata;
  assign bus.cpu_rvalid   = r_rvalid;
  assign bus.load_err     = r_err;
  assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_imem_load_arb.sv
// Randomised scoreboard bench for imem_load_arb: stimulus queues expected memory
// writes and fetch data, a negedge monitor pops and compares them.
module tb_imem_load_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_fill = 1'b1;
  bit   model_run = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  imem_load_arb_if #(.AW(8), .DW(24)) bus ();

  imem_load_arb #(.AW(8), .DW(24), .BPW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [23:0] tb_mem  [256];
  logic [23:0] ref_mem [256];
  logic [31:0] exp_wr_q [$];
  logic [23:0] exp_rd_q [$];
  logic [7:0]  prog_q   [$];

  function automatic logic [23:0] seed_word(input int i);
    return 24'(i * 32'h9E3779B1) ^ 24'h5A5A5A;
  endfunction

  // External memory: combinational read, write on the clock edge.
  assign bus.mem_rdata = tb_mem[bus.mem_addr];
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= seed_word(i);
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Monitor: every write and every fetch response must match the next expected item.
  always @(negedge clk) begin
    logic [31:0] ew;
    logic [23:0] er;
    if (bus.mem_we) begin
      checks++;
      if (rst) begin
        errors++;
        $display("FAIL mem_we_in_reset: got we=1 at addr %0h, required we=0", bus.mem_addr);
      end else if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write: got write %0h@%0h, required no write", bus.mem_wdata, bus.mem_addr);
      end else begin
        ew = exp_wr_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== ew) begin
          errors++;
          $display("FAIL mem_write: got %0h@%0h, required %0h@%0h",
                   bus.mem_wdata, bus.mem_addr, ew[23:0], ew[31:24]);
        end else begin
          $display("write  %06h @ %02h ok", bus.mem_wdata, bus.mem_addr);
        end
      end
    end
    if (bus.cpu_rvalid) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_read: got rvalid data %0h, required no rvalid", bus.cpu_rdata);
      end else begin
        er = exp_rd_q.pop_front();
        if (bus.cpu_rdata !== er) begin
          errors++;
          $display("FAIL cpu_read: got %0h, required %0h", bus.cpu_rdata, er);
        end else begin
          $display("read   %06h ok", bus.cpu_rdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {bus.cpu_rdata, bus.cpu_rvalid, bus.cpu_hold, bus.ld_ready, bus.load_busy,
                 bus.load_err, bus.words_loaded, bus.mem_we, bus.mem_wdata}, 64'd0);
  endtask

  // One clock; a fetch issued while the model says RUN is expected back next cycle.
  task automatic tick();
    if (bus.cpu_req && model_run && !rst) exp_rd_q.push_back(ref_mem[bus.cpu_addr]);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
    bit took;
    int guard = 0;
    bus.ld_data = b;
    bus.ld_last = last;
    do begin
      bus.ld_valid = !gaps || ($urandom_range(0, 2) != 0);
      if (bus.cpu_req) bus.cpu_addr = 8'($urandom);
      took = bus.ld_valid && bus.ld_ready;
      tick();
      guard++;
    end while (!took && guard < 64);
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: got no ld_ready within 64 cycles, required acceptance of %0h", b);
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Reference loader: pack bytes MSB-first, words at 0,1,..., stop after 256 words.
  task automatic load_program(input bit use_last, input bit gaps);
    logic [23:0] word = '0;
    logic [7:0]  b;
    int  k = 0;
    int  w = 0;
    int  n = prog_q.size();
    bit  err = 1'b0;
    bit  last;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    model_run = 1'b0;
    check("hold_rise", bus.cpu_hold, 1);
    check("err_clear", bus.load_err, 0);
    check("words_clear", bus.words_loaded, 0);
    for (int j = 0; j < n; j++) begin
      b = prog_q[j];
      last = use_last && (j == n - 1);
      if (w >= 256) begin
        check("ready_after_full", bus.ld_ready, 0);
        tick();
        continue;
      end
      send_byte(b, last, gaps);
      word[23-8*k -: 8] = b;
      k++;
      if (k == 3 || last) begin
        exp_wr_q.push_back({8'(w), word});
        ref_mem[w] = word;
        if (k != 3) err = 1'b1;
        w++;
        k = 0;
        word = '0;
        if (w == 256 && !last) err = 1'b1;
      end
    end
    tick();
    model_run = 1'b1;
    check("hold_fall", bus.cpu_hold, 0);
    check("busy_fall", bus.load_busy, 0);
    check("words_loaded", bus.words_loaded, 64'(w));
    check("load_err", bus.load_err, 64'(err));
    $display("load   %0d bytes -> %0d words err=%0d", n, w, err);
    prog_q.delete();
  endtask

  task automatic rand_prog(input int nbytes);
    for (int i = 0; i < nbytes; i++) prog_q.push_back(8'($urandom));
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cpu_req  = ($urandom_range(0, 3) != 0);
      bus.cpu_addr = (i < 2) ? 8'(i) : 8'($urandom);
      tick();
    end
    bus.cpu_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      bus.ld_start = 1'($urandom);
      bus.ld_valid = 1'($urandom);
      bus.ld_data  = 8'($urandom);
      bus.ld_last  = 1'($urandom);
      bus.cpu_req  = 1'($urandom);
      bus.cpu_addr = 8'($urandom);
      tick();
      mem_fill = 1'b0;
    end
    rst = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    #1;
    check_zero("reset_outputs");

    rand_reads(20);

    // Two-word load with fixed bytes, then a fetch of address 1.
    prog_q = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    load_program(1'b1, 1'b0);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 8'd1;
    tick();
    bus.cpu_req = 1'b0;
    check("fetch_valid", bus.cpu_rvalid, 1);
    check("fetch_data", bus.cpu_rdata, 24'hABCDEF);
    tick();
    check("rvalid_pulse", bus.cpu_rvalid, 0);

    // Partial final word.
    prog_q = '{8'h11, 8'h22};
    load_program(1'b1, 1'b0);
    rand_reads(6);

    // Contention: fetch every cycle across ld_start, loader with gaps.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 8'($urandom);
    rand_prog(12);
    load_program(1'b1, 1'b1);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    rand_reads(10);

    // Overflow: 259 words, no ld_last.
    rand_prog(259 * 3);
    load_program(1'b0, 1'b0);
    rand_reads(20);

    // Reset in the middle of a word.
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    model_run = 1'b0;
    send_byte(8'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_run = 1'b1;
    check_zero("reset_midword");

    // Reset landing on a WRITE cycle.
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    model_run = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    check("we_before_reset", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    check("we_in_reset", bus.mem_we, 0);
    tick();
    rst = 1'b0;
    model_run = 1'b1;
    check_zero("reset_write");

    // Fresh load restarts at address 0.
    rand_prog(6);
    load_program(1'b1, 1'b1);
    rand_reads(20);

    check("write_queue_drained", 64'(exp_wr_q.size()), 0);
    check("read_queue_drained", 64'(exp_rd_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_load_arb.md
# imem_load_arb

Access controller for the CPU's 256-word x 24-bit instruction memory. It shares the single memory port between the CPU fetch path (read) and a byte-wide program loader (write). The loader assembles 3-byte words MSB-first, writes them at sequential addresses from 0, and holds the CPU off the memory for the whole load. The memory is external to this block: a combinational read, and a write on the clock edge when `mem_we` is high.

## Interface
- `AW`, default 8: memory address width (256 words).
- `DW`, default 24: instruction width; must equal 8 x `BPW`.
- `BPW`, default 3: bytes per word.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `ld_start`, input, 1: pulse; begins a load (honoured only in RUN).
- `ld_valid`, input, 1: loader byte valid.
- `ld_data`, input, 8: loader byte.
- `ld_last`, input, 1: qualifies the final byte of the program.
- `ld_ready`, output, 1: block accepts a byte this cycle.
- `cpu_req`, input, 1: fetch request.
- `cpu_addr`, input, AW: fetch address.
- `cpu_rdata`, output, DW: registered fetch data.
- `cpu_rvalid`, output, 1: `cpu_rdata` valid (one-cycle pulse).
- `cpu_hold`, output, 1: CPU must stall; memory owned by the loader.
- `mem_addr`, output, AW: memory address.
- `mem_we`, output, 1: memory write enable.
- `mem_wdata`, output, DW: memory write data.
- `mem_rdata`, input, DW: memory combinational read data.
- `load_busy`, output, 1: state is LOAD or WRITE.
- `load_err`, output, 1: sticky error flag; cleared by the next accepted `ld_start`.
- `words_loaded`, output, AW+1: words written by the current/last load.

## Operation
- **States:** RUN, LOAD, WRITE.
- **Reset:** state=RUN; every output is 0, including `cpu_rdata`, `words_loaded` and `load_err`. Memory contents are not touched.
- **RUN:**
  - `mem_addr`=`cpu_addr`, `mem_we`=0, `ld_ready`=0, `cpu_hold`=0.
  - `cpu_req`=1 registers `mem_rdata` into `cpu_rdata` and asserts `cpu_rvalid` the next cycle.
  - `cpu_rdata` holds its value between requests.
  - `ld_start`=1 goes to LOAD. It clears the write pointer, byte count, `words_loaded` and `load_err`.
  - If `cpu_req` and `ld_start` arrive in the same cycle, that read is still served.
- **LOAD:**
  - `cpu_hold`=1, `ld_ready`=1, `mem_we`=0; `cpu_req` is ignored (no `cpu_rvalid`).
  - A byte is accepted when `ld_valid && ld_ready`. Byte k (k=0..2) lands in word bits [23-8k:16-8k].
  - After the third byte, or after `ld_last`, go to WRITE.
  - If `ld_last` arrives on byte 0 or 1, the unfilled low bytes are zero and `load_err` is set.
  - `ld_start` is ignored.
- **WRITE (one cycle):**
  - `mem_we`=1, `mem_addr`=write pointer, `mem_wdata`=assembled word, `ld_ready`=0, `cpu_hold`=1.
  - Write pointer and `words_loaded` increment; byte count and assembly register clear.
  - Next state:
    - RUN if the word carried `ld_last`;
    - RUN with `load_err`=1 if the pointer was 255 (memory full, no wrap to 0);
    - otherwise LOAD.
- `load_busy` = (state != RUN). Bytes offered after leaving LOAD are never accepted.

## Timing
- Fetch latency: 1 cycle from `cpu_req` to `cpu_rvalid`. Back-to-back requests give back-to-back `cpu_rvalid`.
- `cpu_hold` rises the cycle after `ld_start` is accepted. It falls the cycle after the final WRITE; the CPU may issue `cpu_req` in that cycle.
- Load throughput: at best 1 word per 4 cycles (3 byte cycles + 1 WRITE). `ld_valid` gaps stall assembly without losing the byte count.
- `ld_ready` is 0 in the WRITE cycle, so the loader must hold its byte.
- Reset in LOAD or WRITE: next cycle the state is RUN and all outputs are 0. A write in the reset cycle is suppressed (`mem_we`=0). Any partial word is discarded.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with random inputs → all outputs 0, state RUN, `mem_we` never 1.
- **Two-word load:** `ld_start`, then bytes 12,34,56,AB,CD,EF (`ld_last` on EF) with no gaps → writes 0x123456@0 and 0xABCDEF@1. Then `words_loaded`=2, `load_err`=0, `cpu_hold` falls. A following fetch of addr 1 returns 0xABCDEF one cycle later.
- **Partial last word:** load bytes 11,22 with `ld_last` on 22 → 0x112200 written @0, `load_err`=1, `words_loaded`=1. A later `ld_start` clears `load_err`.
- **Overflow:** stream 259 words without `ld_last` → addresses 0..255 written; RUN after the 256th WRITE with `load_err`=1 and `words_loaded`=256. Remaining bytes see `ld_ready`=0.
- **Contention:** `cpu_req` every cycle across `ld_start` → the `ld_start`-cycle read returns valid data, then no `cpu_rvalid` while `cpu_hold`=1. With random `ld_valid` gaps, byte order and written words stay correct.
- **Reset mid-operation:** `rst` in the middle of a word, then again in a WRITE cycle → no memory write in the reset cycle, outputs 0. A fresh load then starts at addr 0.
